uart_rx_sampled: RTL

// - Mid-bit-sampling UART receiver (8N1) for the uart_top link; receives frames from uarttx-style transmitters.
// - Runs directly on the system clk with a bit-period counter; no derived clock.
// - Adds false-start rejection, stop-bit checking and overrun detection.
// - Presents each byte on a one-entry valid/ready holding register.

---
 rtl/uart_rx_sampled.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_sampled.sv
// Mid-bit-sampling 8N1 UART receiver with one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_sampled #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB) + 1;

  localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_sr;
  logic          r_rx_m;
  logic          r_rx_s;
  logic          r_dlv;
  logic          w_tick;

  assign w_tick = (r_cnt == C_LAST);
  assign busy   = (r_state != S_IDLE);

`ifdef UART_RX_PARITY_EN
  logic r_par;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sr      <= '0;
      r_rx_m    <= 1'b1;
      r_rx_s    <= 1'b1;
      r_dlv     <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      r_rx_m    <= rx;
      r_rx_s    <= r_rx_m;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      r_dlv     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // A completed byte lands one cycle after its stop sample
      if (r_dlv) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= r_sr;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        parity_err <= r_par ^ (^r_sr);
`endif
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt <= '0;
            r_sr  <= {r_rx_s, r_sr[7:1]};
            if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_par   <= r_rx_s;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_dlv   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (r_rx_s) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
